// File: rtl/fm_pkg.sv
// Shared types and default widths for the fetch sequencer slice.
package fm_pkg;
  localparam int unsigned PC_W    = 8;
  localparam int unsigned INSTR_W = 9;
  localparam int unsigned OFF_W   = 5;
  localparam int unsigned CNT_W   = 16;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    MEM_WAIT,
    HALT
  } state_t;
endpackage

// File: rtl/pc_adder.sv
// Next-PC computation: pc + sign-extended offset when branching, else pc + 1 (wraps).
module pc_adder #(
  parameter int unsigned PC_W  = 8,
  parameter int unsigned OFF_W = 5
) (
  input  logic [PC_W-1:0]  pc,
  input  logic             branch,
  input  logic [OFF_W-1:0] offset,
  output logic [PC_W-1:0]  next_pc
);
  logic [PC_W-1:0] step;

  always_comb begin
    step = branch ? PC_W'($signed(offset)) : PC_W'(1);
    next_pc = pc + step;
  end
endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch/execute sequencer: fetches from imem, strobes execute, waits on
// data memory, advances the PC and halts at end_pc.
module fetch_sequencer #(
  parameter int unsigned PC_W    = fm_pkg::PC_W,
  parameter int unsigned INSTR_W = fm_pkg::INSTR_W,
  parameter int unsigned OFF_W   = fm_pkg::OFF_W,
  parameter int unsigned CNT_W   = fm_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [PC_W-1:0]    start_pc,
  input  logic [PC_W-1:0]    end_pc,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               is_mem,
  input  logic               mem_done,
  input  logic               branch,
  input  logic [OFF_W-1:0]   offset,
  output logic [PC_W-1:0]    pc,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   cycle_count
);
  import fm_pkg::*;

  state_t           state;
  logic             br_q;
  logic [OFF_W-1:0] off_q;
  logic             br_sel;
  logic [OFF_W-1:0] off_sel;
  logic [PC_W-1:0]  next_pc;
  logic             update;

  // EXEC uses the live branch inputs; MEM_WAIT uses the copy captured in EXEC.
  always_comb begin
    br_sel  = (state == EXEC) ? branch : br_q;
    off_sel = (state == EXEC) ? offset : off_q;
    update  = ((state == EXEC) && !is_mem) || ((state == MEM_WAIT) && mem_done);
  end

  pc_adder #(
    .PC_W (PC_W),
    .OFF_W(OFF_W)
  ) u_pc_adder (
    .pc     (pc),
    .branch (br_sel),
    .offset (off_sel),
    .next_pc(next_pc)
  );

  assign imem_addr = pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cycle_count <= '0;
      br_q        <= 1'b0;
      off_q       <= '0;
    end else begin
      instr_valid <= 1'b0;
      if (busy && (cycle_count != '1)) cycle_count <= cycle_count + 1'b1;

      unique case (state)
        IDLE, HALT: begin
          if (start) begin
            pc          <= start_pc;
            cycle_count <= '0;
            if (start_pc == end_pc) begin
              state <= HALT;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state    <= FETCH;
              imem_req <= 1'b1;
              busy     <= 1'b1;
              done     <= 1'b0;
            end
          end
        end
        FETCH: begin
          if (imem_ack) begin
            instr       <= imem_data;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= EXEC;
          end
        end
        EXEC: begin
          br_q  <= branch;
          off_q <= offset;
          if (is_mem) state <= MEM_WAIT;
        end
        MEM_WAIT: ;
        default: state <= IDLE;
      endcase

      if (update) begin
        pc <= next_pc;
        if (next_pc == end_pc) begin
          state <= HALT;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
      end
    end
  end
endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameters (name, default, meaning): PC_W, 8, program-counter width; INSTR_W, 9, instruction width; OFF_W, 5, signed branch-offset width; CNT_W, 16, cycle-counter width.
REQ-002 Ports (name direction width meaning):
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin execution at start_pc.
- start_pc  in  PC_W  first instruction address.
- end_pc  in  PC_W  halt address.
- imem_req  out  1  instruction-fetch request.
- imem_addr  out  PC_W  fetch address.
- imem_ack  in  1  fetch data valid this cycle.
- imem_data  in  INSTR_W  fetched instruction.
- instr  out  INSTR_W  registered instruction to execute stage.
- instr_valid  out  1  one-cycle execute strobe.
- is_mem  in  1  current instruction uses data memory.
- mem_done  in  1  data-memory access complete.
- branch  in  1  take branch (qualified by execute stage).
- offset  in  OFF_W  signed branch offset.
- pc  out  PC_W  current program counter.
- busy  out  1  high in FETCH, EXEC, MEM_WAIT.
- done  out  1  high in HALT.
- cycle_count  out  CNT_W  cycles spent busy since last start.

Function
REQ-003 FSM states: IDLE, FETCH, EXEC, MEM_WAIT, HALT.
REQ-004 IDLE: start=1 loads pc<=start_pc, clears cycle_count, goes to FETCH; if start_pc==end_pc goes directly to HALT with no fetch.
REQ-005 FETCH: imem_req=1, imem_addr=pc, both held stable until imem_ack; on imem_ack, instr<=imem_data, go to EXEC.
REQ-006 EXEC: instr_valid=1 for exactly this one cycle; branch, offset, is_mem sampled this cycle.
REQ-007 EXEC with is_mem=1 goes to MEM_WAIT; MEM_WAIT holds until mem_done=1; PC update happens on the mem_done cycle using branch/offset latched in EXEC.
REQ-008 EXEC with is_mem=0 updates PC in the same cycle.
REQ-009 Next PC = pc + sign_extend(offset) if branch=1, else pc + 1; arithmetic modulo 2^PC_W (wrap-around, no error).
REQ-010 After PC update: next PC == end_pc goes to HALT, otherwise FETCH.
REQ-011 HALT: done=1 held; start=1 restarts per REQ-004; pc holds the halt address.
REQ-012 start ignored while busy=1.
REQ-013 imem_ack outside FETCH and mem_done outside MEM_WAIT are ignored.
REQ-014 cycle_count increments each cycle busy=1, saturates at 2^CNT_W-1, holds in IDLE/HALT.
REQ-015 Minimum throughput: 2 cycles per non-memory instruction with zero-wait ack (FETCH ack cycle + EXEC).
REQ-016 busy and done are mutually exclusive; both 0 only in IDLE.

Reset
REQ-017 reset asserted: state=IDLE, pc=0, instr=0, instr_valid=0, imem_req=0, done=0, cycle_count=0, immediately (asynchronous), including mid-fetch or mid-MEM_WAIT.
REQ-018 First start honoured on the first rising edge after reset deasserts.

Structure
REQ-019 Shared package fm_pkg holds the state enum and default widths (PC_W, INSTR_W, OFF_W, CNT_W).
REQ-020 Sub-module pc_adder: combinational sign-extend of offset and next-PC computation; FSM and registers stay in fetch_sequencer.

Verification
REQ-021 start_pc=0, end_pc=3, ack same cycle, no branch/mem -> instr_valid pulses at PCs 0,1,2; done=1; pc=3; cycle_count=6.
REQ-022 pc=5, branch=1, offset=5'b11110 (-2) -> next fetch address 3; pc=8'hFF, no branch -> next fetch 8'h00 (wrap).
REQ-023 is_mem=1, mem_done after 4 cycles -> instr_valid single pulse, no fetch request until mem_done cycle, next address per latched branch.
REQ-024 imem_ack delayed 3 cycles -> imem_req/imem_addr stable throughout; start pulsed while busy -> no effect.
REQ-025 start_pc=end_pc=7 -> HALT next cycle, imem_req never asserted, cycle_count=0.
REQ-026 reset asserted during MEM_WAIT -> all outputs at reset values same cycle; subsequent start from start_pc=2 runs normally.
